// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory stage of the 16-bit core.
// Holds the MEM FSM state encoding, data/address widths and timeout counter width.
package mem_stage_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int TMO_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for the memory stage; flags the last permitted WAIT cycle.
// Ports: clk, rst (sync, active-low), i_clr, i_en, o_tc (count == TIMEOUT-1).
module mem_timeout_ctr
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0] ONE    = TMO_W'(1);

   logic [TMO_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + ONE;
      end
   end

   assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: one request per load/store, stalls until done,
// sticky error on unaligned access or timeout. Optional perf counters: MEM_ACCESS_PERF_EN.
// Ports: clk/rst, EX/MEM inputs, memory req/done handshake, MEM/WB outputs, err.
module mem_access_ctrl
   import mem_stage_pkg::*;
#(
`ifdef MEM_ACCESS_PERF_EN
   parameter int CNT_W   = 16,
`endif
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              halt_in,
   input  logic              flush_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wr_data_in,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] read_data_out,
   output logic              stall_out,
   output logic              memwb_en,
   output logic              halt_out,
   output logic              err_out,
   output logic [ADDR_W-1:0] err_addr
`ifdef MEM_ACCESS_PERF_EN
   ,
   output logic [CNT_W-1:0]  ld_count,
   output logic [CNT_W-1:0]  st_count,
   output logic [CNT_W-1:0]  stall_count
`endif
);

   mem_state_t        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_wr;
   logic [DATA_W-1:0] r_hold;
   logic [ADDR_W-1:0] r_err_addr;

   logic w_acc;
   logic w_in_idle;
   logic w_in_wait;
   logic w_idle;
   logic w_wait;
   logic w_err;
   logic w_done;
   logic w_tc;

   assign w_acc = valid_in & ~flush_in
                & (mem_read_in | mem_write_in);

   assign w_in_idle = (r_state == ST_IDLE);
   assign w_in_wait = (r_state == ST_WAIT);

   // Qualified by rst so every handshake output is low in a reset cycle.
   assign w_idle = rst & w_in_idle;
   assign w_wait = rst & w_in_wait;
   assign w_err  = rst & (r_state == ST_ERR);
   assign w_done = w_wait & mem_done;

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk   (clk),
      .rst   (rst),
      .i_clr (~w_in_wait),
      .i_en  (w_in_wait & ~mem_done),
      .o_tc  (w_tc)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wr       <= 1'b0;
         r_hold     <= '0;
         r_err_addr <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_acc) begin
                  if (addr_in[0]) begin
                     r_state    <= ST_ERR;
                     r_err_addr <= addr_in;
                  end else begin
                     r_state <= ST_WAIT;
                     r_addr  <= addr_in;
                     r_wdata <= wr_data_in;
                     // read+write together is a store
                     r_wr    <= mem_write_in;
                  end
               end
            end
            ST_WAIT: begin
               // done beats a timeout in the same cycle
               if (mem_done) begin
                  r_state <= ST_IDLE;
                  if (!r_wr) begin
                     r_hold <= mem_rdata;
                  end
               end else if (w_tc) begin
                  r_state    <= ST_ERR;
                  r_err_addr <= r_addr;
               end
            end
            ST_ERR: begin
               r_state <= ST_ERR;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_req   = w_idle & w_acc & ~addr_in[0];
   assign mem_wr    = w_in_idle ? mem_write_in : r_wr;
   assign mem_addr  = w_in_idle ? addr_in : r_addr;
   assign mem_wdata = w_in_idle ? wr_data_in : r_wdata;

   assign stall_out = (w_idle & w_acc)
                    | (w_wait & ~mem_done)
                    | w_err;

   assign memwb_en  = (w_idle & ~w_acc)
                    | w_done
                    | w_err;

   assign halt_out  = (w_idle & valid_in & halt_in & ~flush_in)
                    | w_err;

   // Load data bypasses the hold register in its completion cycle.
   assign read_data_out = (w_done & ~r_wr) ? mem_rdata : r_hold;

   assign err_out  = (r_state == ST_ERR);
   assign err_addr = r_err_addr;

`ifdef MEM_ACCESS_PERF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_ld_cnt;
   logic [CNT_W-1:0] r_st_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ld_cnt    <= '0;
         r_st_cnt    <= '0;
         r_stall_cnt <= '0;
      end else if (w_in_wait) begin
         if (mem_done) begin
            if (r_wr) begin
               if (r_st_cnt != CNT_MAX) begin
                  r_st_cnt <= r_st_cnt + CNT_ONE;
               end
            end else begin
               if (r_ld_cnt != CNT_MAX) begin
                  r_ld_cnt <= r_ld_cnt + CNT_ONE;
               end
            end
         end else if (r_stall_cnt != CNT_MAX) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         end
      end
   end

   assign ld_count    = r_ld_cnt;
   assign st_count    = r_st_cnt;
   assign stall_count = r_stall_cnt;
`endif

endmodule
